// File: rtl/calculator_pkg.sv
// ---------------------------------------------------------------------------
// calculator_pkg
// Shared widths and the controller state type for the calculator datapath.
//   DATA_W        : operand / adder result width
//   MEM_WORD_SIZE : SRAM and result-buffer word width (two operands per word)
//   ADDR_W        : SRAM word-address width
//   state_t       : sequencing states of calc_controller
// ---------------------------------------------------------------------------
package calculator_pkg;

   localparam int DATA_W        = 32;
   localparam int MEM_WORD_SIZE = 64;
   localparam int ADDR_W        = 10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_LOAD,
      S_ADD,
      S_WRITE,
      S_END
   } state_t;

   // A window is usable when its last address is not below its first one.
   function automatic logic rangeOk(input logic [ADDR_W-1:0] firstAddr,
                                    input logic [ADDR_W-1:0] lastAddr);
      return (lastAddr >= firstAddr);
   endfunction

endpackage

// File: rtl/calc_controller_if.sv
// ---------------------------------------------------------------------------
// calc_controller_if
// SRAM access bus between calc_controller (master) and the synchronous SRAM
// (slave).
//   mem_req_o   : access this cycle
//   mem_we_o    : 1 = write, 0 = read
//   mem_addr_o  : word address
//   mem_wdata_o : write data
//   mem_rdata_i : read data, valid the cycle after a read request
// ---------------------------------------------------------------------------
interface calc_controller_if;
   import calculator_pkg::*;

   logic                     mem_req_o;
   logic                     mem_we_o;
   logic [ADDR_W-1:0]        mem_addr_o;
   logic [MEM_WORD_SIZE-1:0] mem_wdata_o;
   logic [MEM_WORD_SIZE-1:0] mem_rdata_i;

   modport master (
      output mem_req_o,
      output mem_we_o,
      output mem_addr_o,
      output mem_wdata_o,
      input  mem_rdata_i
   );

   modport slave (
      input  mem_req_o,
      input  mem_we_o,
      input  mem_addr_o,
      input  mem_wdata_o,
      output mem_rdata_i
   );

endinterface

// File: rtl/calc_controller.sv
// ---------------------------------------------------------------------------
// calc_controller
// Sequencing FSM for the calculator datapath. Reads 64-bit operand words from
// SRAM, presents their two 32-bit halves to the adder, steers the result
// buffer half-select, and writes each assembled 64-bit buffer word back to
// SRAM (one write per two operand words).
//   clk_i / rst_ni        : clock, asynchronous active-low reset
//   start_i               : one-cycle start pulse (ignored while busy)
//   read_*_addr_i         : inclusive operand word window
//   write_*_addr_i        : inclusive result word window
//   mem                   : SRAM bus (master side)
//   op_a_o / op_b_o       : registered adder operands
//   loc_sel_o             : registered buffer half select (0 lower, 1 upper)
//   buffer_i              : result buffer contents
//   busy_o / done_o / err_o : status, done and error pulses
// ---------------------------------------------------------------------------
module calc_controller
   import calculator_pkg::*;
(
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   input  logic [ADDR_W-1:0]        read_start_addr_i,
   input  logic [ADDR_W-1:0]        read_end_addr_i,
   input  logic [ADDR_W-1:0]        write_start_addr_i,
   input  logic [ADDR_W-1:0]        write_end_addr_i,
   calc_controller_if.master        mem,
   output logic [DATA_W-1:0]        op_a_o,
   output logic [DATA_W-1:0]        op_b_o,
   output logic                     loc_sel_o,
   input  logic [MEM_WORD_SIZE-1:0] buffer_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o
);

   state_t              r_state;
   logic [ADDR_W-1:0]   r_rdPtr;
   logic [ADDR_W-1:0]   r_wrPtr;
   logic [ADDR_W-1:0]   r_rdEnd;
   logic [ADDR_W-1:0]   r_wrEnd;
   logic                r_half;
   logic [DATA_W-1:0]   r_opA;
   logic [DATA_W-1:0]   r_opB;
   logic                r_locSel;
   logic                r_err;

   state_t              w_nextState;
   logic [ADDR_W-1:0]   w_rdPtrNext;
   logic [ADDR_W-1:0]   w_wrPtrNext;
   logic [ADDR_W-1:0]   w_rdEndNext;
   logic [ADDR_W-1:0]   w_wrEndNext;
   logic                w_halfNext;
   logic [DATA_W-1:0]   w_opANext;
   logic [DATA_W-1:0]   w_opBNext;
   logic                w_locSelNext;
   logic                w_errNext;

   // State and datapath registers. Reset drops everything to IDLE/zero at
   // once so an in-flight write request is withdrawn in the same cycle.
   // The window ends are captured at start so the run is immune to the
   // address inputs changing while busy.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= S_IDLE;
         r_rdPtr  <= '0;
         r_wrPtr  <= '0;
         r_rdEnd  <= '0;
         r_wrEnd  <= '0;
         r_half   <= 1'b0;
         r_opA    <= '0;
         r_opB    <= '0;
         r_locSel <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_nextState;
         r_rdPtr  <= w_rdPtrNext;
         r_wrPtr  <= w_wrPtrNext;
         r_rdEnd  <= w_rdEndNext;
         r_wrEnd  <= w_wrEndNext;
         r_half   <= w_halfNext;
         r_opA    <= w_opANext;
         r_opB    <= w_opBNext;
         r_locSel <= w_locSelNext;
         r_err    <= w_errNext;
      end
   end

   // Next-state and bus outputs. Operands and loc_sel only move on the LOAD
   // edge because the buffer rewrites the selected half every cycle; holding
   // them steady elsewhere keeps that rewrite idempotent. The first word of
   // a pair lands in the lower half, the second in the upper half; a lone
   // final word is written with whatever the upper half already holds.
   always_comb begin
      w_nextState     = r_state;
      w_rdPtrNext     = r_rdPtr;
      w_wrPtrNext     = r_wrPtr;
      w_rdEndNext     = r_rdEnd;
      w_wrEndNext     = r_wrEnd;
      w_halfNext      = r_half;
      w_opANext       = r_opA;
      w_opBNext       = r_opB;
      w_locSelNext    = r_locSel;
      w_errNext       = 1'b0;
      mem.mem_req_o   = 1'b0;
      mem.mem_we_o    = 1'b0;
      mem.mem_addr_o  = '0;
      mem.mem_wdata_o = '0;
      done_o          = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               if (rangeOk(read_start_addr_i, read_end_addr_i) &&
                   rangeOk(write_start_addr_i, write_end_addr_i)) begin
                  w_rdPtrNext = read_start_addr_i;
                  w_wrPtrNext = write_start_addr_i;
                  w_rdEndNext = read_end_addr_i;
                  w_wrEndNext = write_end_addr_i;
                  w_halfNext  = 1'b0;
                  w_nextState = S_READ;
               end else begin
                  w_errNext = 1'b1;
               end
            end
         end

         S_READ: begin
            mem.mem_req_o  = 1'b1;
            mem.mem_addr_o = r_rdPtr;
            w_nextState    = S_LOAD;
         end

         S_LOAD: begin
            w_opANext    = mem.mem_rdata_i[DATA_W-1:0];
            w_opBNext    = mem.mem_rdata_i[MEM_WORD_SIZE-1:DATA_W];
            w_locSelNext = r_half;
            w_nextState  = S_ADD;
         end

         S_ADD: begin
            if (!r_half && (r_rdPtr != r_rdEnd)) begin
               w_rdPtrNext = r_rdPtr + ADDR_W'(1);
               w_halfNext  = 1'b1;
               w_nextState = S_READ;
            end else begin
               w_nextState = S_WRITE;
            end
         end

         S_WRITE: begin
            mem.mem_req_o   = 1'b1;
            mem.mem_we_o    = 1'b1;
            mem.mem_addr_o  = r_wrPtr;
            mem.mem_wdata_o = buffer_i;
            if (r_rdPtr == r_rdEnd) begin
               w_nextState = S_END;
            end else if (r_wrPtr == r_wrEnd) begin
               w_errNext   = 1'b1;
               w_nextState = S_END;
            end else begin
               w_rdPtrNext = r_rdPtr + ADDR_W'(1);
               w_wrPtrNext = r_wrPtr + ADDR_W'(1);
               w_halfNext  = 1'b0;
               w_nextState = S_READ;
            end
         end

         S_END: begin
            done_o      = 1'b1;
            w_nextState = S_IDLE;
         end

         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   assign busy_o    = (r_state != S_IDLE);
   assign op_a_o    = r_opA;
   assign op_b_o    = r_opB;
   assign loc_sel_o = r_locSel;
   assign err_o     = r_err;

endmodule

// File: doc/calc_controller.md
Name: calc_controller

Overview:
- Sequencing FSM for the calculator datapath, directly upstream of the 64-bit result buffer.
- Reads 64-bit operand words from the synchronous SRAM and registers the two 32-bit operands for the adder.
- Drives the buffer's half-select (loc_sel), then writes the assembled 64-bit buffer word back to SRAM.
- One write-back per two operand words; runs over a start/end address window on a start pulse.

Parameters:
ADDR_W, 10, SRAM word-address width
DATA_W, 32, operand/result width (from calculator_pkg)
MEM_WORD_SIZE, 64, SRAM/buffer word width (from calculator_pkg; must equal 2*DATA_W)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
start_i  in  1  one-cycle start pulse
read_start_addr_i  in  ADDR_W  first operand word
read_end_addr_i  in  ADDR_W  last operand word (inclusive)
write_start_addr_i  in  ADDR_W  first result word
write_end_addr_i  in  ADDR_W  last permitted result word (inclusive)
mem_req_o  out  1  SRAM access this cycle
mem_we_o  out  1  1=write, 0=read
mem_addr_o  out  ADDR_W  SRAM address
mem_wdata_o  out  MEM_WORD_SIZE  SRAM write data
mem_rdata_i  in  MEM_WORD_SIZE  SRAM read data, valid 1 cycle after read request
op_a_o  out  DATA_W  adder operand A (registered)
op_b_o  out  DATA_W  adder operand B (registered)
loc_sel_o  out  1  buffer half select (0=lower, 1=upper), registered
buffer_i  in  MEM_WORD_SIZE  result buffer contents
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle completion pulse
err_o  out  1  one-cycle error pulse

Behaviour:
- Reset (async assert, sync release): state=IDLE. Outputs op_a_o, op_b_o, loc_sel_o, mem_*_o, done_o, err_o, busy_o all 0. Internal pointers and half flag cleared.
- Reset mid-operation aborts immediately; no partial write completes.
- States: IDLE, READ, LOAD, ADD, WRITE, END.
- IDLE:
  - On start_i with read_end>=read_start and write_end>=write_start: latch rd_ptr=read_start, wr_ptr=write_start, half=0, go to READ.
  - If either range is inverted: pulse err_o next cycle and stay in IDLE.
- READ: mem_req_o=1, mem_we_o=0, mem_addr_o=rd_ptr -> LOAD.
- LOAD: on the clock edge, op_a_o<=mem_rdata_i[DATA_W-1:0], op_b_o<=mem_rdata_i[MEM_WORD_SIZE-1:DATA_W], loc_sel_o<=half -> ADD.
- ADD: operands and loc_sel stable; the buffer captures the sum at the end of this cycle.
  - half=0 and rd_ptr!=read_end: rd_ptr++, half<=1 -> READ.
  - Otherwise -> WRITE.
- WRITE: mem_req_o=1, mem_we_o=1, mem_addr_o=wr_ptr, mem_wdata_o=buffer_i.
  - rd_ptr==read_end -> END.
  - wr_ptr==write_end with reads still pending -> END, and pulse err_o (write window exhausted).
  - Otherwise rd_ptr++, wr_ptr++, half<=0 -> READ.
- END: done_o=1 for one cycle -> IDLE.
- op_a_o, op_b_o and loc_sel_o change only on LOAD edges. The buffer writes every cycle, so these values must stay stable between LOAD edges; rewriting the same value is harmless.
- Odd operand count: the last word goes to the lower half and is written with a stale upper half. This is defined behaviour, no error.
- start_i while busy_o=1 is ignored.
- Pointer arithmetic is modulo 2^ADDR_W. The controller does not inspect adder overflow; the adder wraps at DATA_W.
- Latency: 7 cycles per full 64-bit output word (READ, LOAD, ADD twice, plus WRITE). done_o asserts 8 cycles after start is accepted for a single pair.

Decomposition:
- calculator_pkg holds:
  - DATA_W and MEM_WORD_SIZE (existing);
  - ADDR_W;
  - an enum state_t {S_IDLE, S_READ, S_LOAD, S_ADD, S_WRITE, S_END}.
- No sub-module is needed. An optional addr_window_check helper for the range/termination compares is acceptable.
- Top-level calculator instantiates this controller, the adder and result_buffer.

Test Plan:
- Single pair: mem[0]={32'd5,32'd3}, mem[1]={32'd10,32'd20}, read 0..1, write 0x100. Expect mem[0x100]=64'h0000001E_00000008, done_o 8 cycles after start, err_o=0.
- Multi-word: read 0..3, write 0x10..0x11, all words {1,1}. Expect mem[0x10]=mem[0x11]=64'h00000002_00000002, exactly 2 write requests, done_o once.
- Overflow/odd count: read 5..5, mem[5]={32'hFFFFFFFF,32'h1}. Expect lower half 0, upper half stale value, one write, no err.
- Window exhausted: read 0..3, write 0x20..0x20. Expect one write to 0x20, then err_o and done_o pulses, busy_o drops.
- Inverted range: read_start=4, read_end=2. Expect err_o one cycle, no mem_req_o, busy_o stays 0; start_i during busy is ignored, with no second done_o.
- Async reset: assert rst_ni low during WRITE (async edge mid-cycle). Expect mem_req_o=0 immediately and all outputs 0; after release a new start completes normally.
